// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl bus: instruction-side controls in,
// branch LUT tag/target and fetch status out.
interface pc_fetch_ctrl_if #(
  parameter int PC_W  = 12,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             stall;
  logic             halt_req;
  logic             branch_en;
  logic             cond;
  logic [TAG_W-1:0] br_tag;
  logic [TAG_W-1:0] lut_tag;
  logic [PC_W-1:0]  lut_target;
  logic [PC_W-1:0]  prog_ctr;
  logic             fetch_valid;
  logic             done;
  logic [CNT_W-1:0] instr_count;

  modport slave (
    input  start, stall, halt_req,
    input  branch_en, cond, br_tag,
    input  lut_target,
    output lut_tag, prog_ctr,
    output fetch_valid, done,
    output instr_count
  );

  modport master (
    output start, stall, halt_req,
    output branch_en, cond, br_tag,
    output lut_target,
    input  lut_tag, prog_ctr,
    input  fetch_valid, done,
    input  instr_count
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer feeding the
// branch-target LUT; one bubble per taken branch.
module pc_fetch_ctrl #(
  parameter int              PC_W       = 12,
  parameter int              TAG_W      = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input logic           clk,
  input logic           rst_n,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BR_WAIT,
    HALT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [PC_W-1:0]  pc_q, pc_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc;
  logic [TAG_W-1:0] tag_q, tag_nx;
  logic             fv_q, done_q;

  assign bus.prog_ctr    = pc_q;
  assign bus.instr_count = cnt_q;
  assign bus.lut_tag     = tag_q;
  assign bus.fetch_valid = fv_q;
  assign bus.done        = done_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q
                                      : cnt_q + 1'b1;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and next datapath values
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    cnt_nx   = cnt_q;
    tag_nx   = tag_q;
    unique case (state)
      IDLE, HALT: begin
        if (bus.start) begin
          state_nx = RUN;
          pc_nx    = START_ADDR;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          cnt_nx = cnt_inc;
          if (bus.halt_req) begin
            state_nx = HALT;
          end else if (bus.branch_en && bus.cond) begin
            state_nx = BR_WAIT;
            tag_nx   = bus.br_tag;
          end else begin
            pc_nx = pc_q + 1'b1;
          end
        end
      end
      BR_WAIT: begin
        state_nx = RUN;
        pc_nx    = bus.lut_target;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= START_ADDR;
      cnt_q  <= '0;
      tag_q  <= '0;
      fv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pc_q   <= pc_nx;
      cnt_q  <= cnt_nx;
      tag_q  <= tag_nx;
      fv_q   <= (state_nx == RUN);
      done_q <= (state_nx == HALT);
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: vector table plus
// async-reset-in-bubble and counter saturation runs.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.PC_W(12), .TAG_W(8), .CNT_W(16)) bf ();
  pc_fetch_ctrl_if #(.PC_W(12), .TAG_W(8), .CNT_W(4))  b4 ();

  pc_fetch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bf)
  );

  pc_fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  function automatic logic [11:0] lut_fn(logic [7:0] t);
    case (t)
      8'h07:   return 12'h0A4;
      8'h3F:   return 12'hFFE;
      default: return {4'h1, t};
    endcase
  endfunction

  // branch-target LUT model
  always_comb bf.lut_target = lut_fn(bf.lut_tag);
  always_comb b4.lut_target = 12'h000;

  typedef struct {
    logic        st, sl, hr, be, cd;
    logic [7:0]  tg;
    logic [11:0] pc;
    logic        fv, dn;
    logic [15:0] cnt;
    logic [7:0]  lt;
  } vec_t;

  vec_t tv[21];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [11:0] pc,
                         logic fv, logic dn,
                         logic [15:0] cnt, logic [7:0] lt);
    chk({nm, " pc"},   32'(bf.prog_ctr),    32'(pc));
    chk({nm, " fv"},   32'(bf.fetch_valid), 32'(fv));
    chk({nm, " done"}, 32'(bf.done),        32'(dn));
    chk({nm, " cnt"},  32'(bf.instr_count), 32'(cnt));
    chk({nm, " tag"},  32'(bf.lut_tag),     32'(lt));
  endtask

  task automatic drive(logic st, logic sl, logic hr,
                       logic be, logic cd, logic [7:0] tg);
    bf.start     = st;
    bf.stall     = sl;
    bf.halt_req  = hr;
    bf.branch_en = be;
    bf.cond      = cd;
    bf.br_tag    = tg;
  endtask

  initial begin
    //         st sl hr be cd tg     pc      fv dn cnt   lt
    tv[0]  = '{0, 0, 0, 1, 1, 8'h55, 12'h000, 0, 0, 16'd0, 8'h00};
    tv[1]  = '{1, 0, 0, 0, 0, 8'h00, 12'h000, 1, 0, 16'd0, 8'h00};
    tv[2]  = '{0, 0, 0, 0, 0, 8'h00, 12'h001, 1, 0, 16'd1, 8'h00};
    tv[3]  = '{0, 0, 0, 0, 0, 8'h00, 12'h002, 1, 0, 16'd2, 8'h00};
    tv[4]  = '{0, 0, 0, 0, 0, 8'h00, 12'h003, 1, 0, 16'd3, 8'h00};
    tv[5]  = '{0, 0, 0, 1, 1, 8'h07, 12'h003, 0, 0, 16'd4, 8'h07};
    tv[6]  = '{1, 1, 1, 1, 1, 8'hAA, 12'h0A4, 1, 0, 16'd4, 8'h07};
    tv[7]  = '{0, 0, 0, 0, 0, 8'h00, 12'h0A5, 1, 0, 16'd5, 8'h07};
    tv[8]  = '{0, 0, 0, 1, 0, 8'h99, 12'h0A6, 1, 0, 16'd6, 8'h07};
    tv[9]  = '{0, 1, 1, 0, 0, 8'h00, 12'h0A6, 1, 0, 16'd6, 8'h07};
    tv[10] = '{0, 1, 1, 0, 0, 8'h00, 12'h0A6, 1, 0, 16'd6, 8'h07};
    tv[11] = '{0, 1, 0, 1, 1, 8'h11, 12'h0A6, 1, 0, 16'd6, 8'h07};
    tv[12] = '{0, 0, 1, 0, 0, 8'h00, 12'h0A6, 0, 1, 16'd7, 8'h07};
    tv[13] = '{0, 1, 0, 1, 1, 8'h22, 12'h0A6, 0, 1, 16'd7, 8'h07};
    tv[14] = '{1, 0, 0, 0, 0, 8'h00, 12'h000, 1, 0, 16'd0, 8'h07};
    tv[15] = '{0, 0, 0, 1, 1, 8'h3F, 12'h000, 0, 0, 16'd1, 8'h3F};
    tv[16] = '{0, 0, 0, 0, 0, 8'h00, 12'hFFE, 1, 0, 16'd1, 8'h3F};
    tv[17] = '{0, 0, 0, 0, 0, 8'h00, 12'hFFF, 1, 0, 16'd2, 8'h3F};
    tv[18] = '{0, 0, 0, 0, 0, 8'h00, 12'h000, 1, 0, 16'd3, 8'h3F};
    tv[19] = '{0, 0, 0, 0, 0, 8'h00, 12'h001, 1, 0, 16'd4, 8'h3F};
    tv[20] = '{1, 0, 0, 0, 0, 8'h00, 12'h002, 1, 0, 16'd5, 8'h3F};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00);
    b4.start = 0; b4.stall = 0; b4.halt_req = 0;
    b4.branch_en = 0; b4.cond = 0; b4.br_tag = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 12'h000, 0, 0, 16'd0, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].st, tv[i].sl, tv[i].hr,
            tv[i].be, tv[i].cd, tv[i].tg);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), tv[i].pc, tv[i].fv,
              tv[i].dn, tv[i].cnt, tv[i].lt);
    end

    // taken branch, then async reset inside the bubble
    drive(0, 0, 0, 1, 1, 8'h07);
    @(posedge clk);
    #1;
    chk_all("arst_pre", 12'h002, 0, 0, 16'd6, 8'h07);
    drive(0, 0, 0, 0, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst_now", 12'h000, 0, 0, 16'd0, 8'h00);
    @(posedge clk);
    #1;
    chk_all("arst_hold", 12'h000, 0, 0, 16'd0, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("arst_idle", 12'h000, 0, 0, 16'd0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    chk_all("arst_start", 12'h000, 1, 0, 16'd0, 8'h00);
    drive(0, 0, 0, 0, 0, 8'h00);

    // 4-bit counter saturates at 0xF
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    b4.start = 1'b0;
    chk("sat c0", 32'(b4.instr_count), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 14 || k == 15 || k == 16 || k == 20)
        chk($sformatf("sat c%0d", k), 32'(b4.instr_count),
            (k < 15) ? 32'(k) : 32'hF);
    end
    chk("sat pc", 32'(b4.prog_ctr), 32'h014);
    chk("sat fv", 32'(b4.fetch_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
